// File: rtl/switch_pkg.sv
// Shared definitions for pin-input debounce logic: FSM encoding and default timing.
`default_nettype none

package switch_pkg;

   localparam int CLK_HZ      = 50_000_000;
   localparam int DEBOUNCE_MS = 10;

   localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
   localparam int DEFAULT_LONG_CYCLES     = CLK_HZ;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } sw_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a configurable reset level.
`default_nettype none

module sync_2ff #(
   parameter bit RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_sync
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = i_async;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign o_sync = sync_q;

endmodule

`default_nettype wire

// File: rtl/switch_debounce.sv
// Debounces a raw button pin into a stable level plus one-cycle press/release pulses.
// Optional long-press pulse enabled by defining SWITCH_DEBOUNCE_LONG_PRESS_EN.
`default_nettype none

module switch_debounce
   import switch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_Switch,
   output logic o_Switch_Level,
   output logic o_Press_Pulse,
   output logic o_Release_Pulse,
   output logic o_Long_Press
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce_cycles
      $error("switch_debounce: DEBOUNCE_CYCLES must be >= 2");
   end
   if (LONG_CYCLES < 2) begin : g_bad_long_cycles
      $error("switch_debounce: LONG_CYCLES must be >= 2");
   end

   logic       sync_pin;
   logic       pressed;
   sw_state_e  state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic       level_q, level_d;
   logic       press_q, press_d;
   logic       release_q, release_d;

   // Synchroniser idles at the released pin level so reset release never looks like a press.
   sync_2ff #(
      .RESET_VAL (ACTIVE_LOW)
   ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (i_Switch),
      .o_sync  (sync_pin)
   );

   assign pressed = ACTIVE_LOW ? ~sync_pin : sync_pin;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pressed) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!pressed) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HELD;
               press_d = 1'b1;
               level_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HELD: begin
            if (!pressed) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (pressed) begin
               state_d = HELD;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = IDLE;
               release_d = 1'b1;
               level_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign o_Switch_Level  = level_q;
   assign o_Press_Pulse   = press_q;
   assign o_Release_Pulse = release_q;

`ifdef SWITCH_DEBOUNCE_LONG_PRESS_EN
   localparam int                HOLD_W    = $clog2(LONG_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              long_done_q, long_done_d;
   logic              long_q, long_d;

   // Hold time spans release bounces; only a freshly accepted press restarts it.
   always_comb begin
      hold_cnt_d  = hold_cnt_q;
      long_done_d = long_done_q;
      long_d      = 1'b0;
      if ((state_q == PRESS_WAIT) && (state_d == HELD)) begin
         hold_cnt_d  = '0;
         long_done_d = 1'b0;
      end else if ((state_q == HELD) || (state_q == RELEASE_WAIT)) begin
         if (hold_cnt_q != HOLD_LAST) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
         end else if (!long_done_q) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_q  <= '0;
         long_done_q <= 1'b0;
         long_q      <= 1'b0;
      end else begin
         hold_cnt_q  <= hold_cnt_d;
         long_done_q <= long_done_d;
         long_q      <= long_d;
      end
   end

   assign o_Long_Press = long_q;
`else
   assign o_Long_Press = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_switch_debounce.sv
// Directed self-checking bench for switch_debounce (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, active-low pin).
`default_nettype none

module tb_switch_debounce;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic sw    = 1'b1;
   logic level, press, rel, long_p;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef SWITCH_DEBOUNCE_LONG_PRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   switch_debounce #(
      .DEBOUNCE_CYCLES (4),
      .ACTIVE_LOW      (1'b1),
      .LONG_CYCLES     (20)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_Switch        (sw),
      .o_Switch_Level  (level),
      .o_Press_Pulse   (press),
      .o_Release_Pulse (rel),
      .o_Long_Press    (long_p)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      rst_n = 1'b0;
      sw    = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({level, press, rel, long_p} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_hold: outputs=%b expected=0000", {level, press, rel, long_p});
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         n_tests++;
         if ({level, press, rel, long_p} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_idle cycle %0d: outputs=%b expected=0000", k, {level, press, rel, long_p});
         end
      end
   endtask

   task automatic test_clean_press();
      logic [2:0] exp;
      sw = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         exp = {(k >= 7), (k == 7), 1'b0};
         n_tests++;
         if ({level, press, rel} !== exp) begin
            n_fail++;
            $display("FAIL clean_press cycle %0d: {level,press,rel}=%b expected=%b", k, {level, press, rel}, exp);
         end
      end
      sw = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         exp = {(k < 7), 1'b0, (k == 7)};
         n_tests++;
         if ({level, press, rel} !== exp) begin
            n_fail++;
            $display("FAIL clean_release cycle %0d: {level,press,rel}=%b expected=%b", k, {level, press, rel}, exp);
         end
      end
   endtask

   task automatic test_bounce();
      logic [2:0] exp;
      int         n_press;
      int         cyc;
      cyc = 0;
      for (int seg = 0; seg < 4; seg++) begin
         sw = (seg % 2 == 1);
         for (int k = 0; k < ((seg == 1) ? 1 : (seg == 3) ? 6 : 3); k++) begin
            @(negedge clk);
            cyc++;
            n_tests++;
            if ({level, press, rel} !== 3'b000) begin
               n_fail++;
               $display("FAIL bounce_reject cycle %0d: {level,press,rel}=%b expected=000", cyc, {level, press, rel});
            end
         end
      end
      n_press = 0;
      sw = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (press) n_press++;
         exp = {(k >= 7), (k == 7), 1'b0};
         n_tests++;
         if ({level, press, rel} !== exp) begin
            n_fail++;
            $display("FAIL bounce_then_press cycle %0d: {level,press,rel}=%b expected=%b", k, {level, press, rel}, exp);
         end
      end
      n_tests++;
      if (n_press !== 1) begin
         n_fail++;
         $display("FAIL bounce_press_count: pulses=%0d expected=1", n_press);
      end
      sw = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         exp = {(k < 7), 1'b0, (k == 7)};
         n_tests++;
         if ({level, press, rel} !== exp) begin
            n_fail++;
            $display("FAIL bounce_release cycle %0d: {level,press,rel}=%b expected=%b", k, {level, press, rel}, exp);
         end
      end
   endtask

   task automatic test_release_bounce();
      logic [2:0] exp;
      sw = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         exp = {(k >= 7), (k == 7), 1'b0};
         n_tests++;
         if ({level, press, rel} !== exp) begin
            n_fail++;
            $display("FAIL rb_press cycle %0d: {level,press,rel}=%b expected=%b", k, {level, press, rel}, exp);
         end
      end
      for (int k = 1; k <= 4; k++) begin
         sw = (k <= 2);
         @(negedge clk);
         n_tests++;
         if ({level, press, rel} !== 3'b100) begin
            n_fail++;
            $display("FAIL rb_bounce cycle %0d: {level,press,rel}=%b expected=100", k, {level, press, rel});
         end
      end
      sw = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         exp = {(k < 7), 1'b0, (k == 7)};
         n_tests++;
         if ({level, press, rel} !== exp) begin
            n_fail++;
            $display("FAIL rb_release cycle %0d: {level,press,rel}=%b expected=%b", k, {level, press, rel}, exp);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [2:0] exp;
      // Reset while held: level must drop without waiting for a clock edge.
      sw = 1'b0;
      repeat (7) @(negedge clk);
      n_tests++;
      if (level !== 1'b1) begin
         n_fail++;
         $display("FAIL rm_held_level: level=%b expected=1", level);
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({level, press, rel, long_p} !== 4'b0000) begin
         n_fail++;
         $display("FAIL rm_async_held: outputs=%b expected=0000", {level, press, rel, long_p});
      end
      sw = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         n_tests++;
         if ({level, press, rel} !== 3'b000) begin
            n_fail++;
            $display("FAIL rm_after_release cycle %0d: {level,press,rel}=%b expected=000", k, {level, press, rel});
         end
      end
      // Reset in PRESS_WAIT with cnt=2, pin kept low through reset release.
      sw = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         n_tests++;
         if ({level, press, rel} !== 3'b000) begin
            n_fail++;
            $display("FAIL rm_press_wait cycle %0d: {level,press,rel}=%b expected=000", k, {level, press, rel});
         end
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({level, press, rel, long_p} !== 4'b0000) begin
         n_fail++;
         $display("FAIL rm_async_wait: outputs=%b expected=0000", {level, press, rel, long_p});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         exp = {(k >= 7), (k == 7), 1'b0};
         n_tests++;
         if ({level, press, rel} !== exp) begin
            n_fail++;
            $display("FAIL rm_repress cycle %0d: {level,press,rel}=%b expected=%b", k, {level, press, rel}, exp);
         end
      end
      sw = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         exp = {(k < 7), 1'b0, (k == 7)};
         n_tests++;
         if ({level, press, rel} !== exp) begin
            n_fail++;
            $display("FAIL rm_release cycle %0d: {level,press,rel}=%b expected=%b", k, {level, press, rel}, exp);
         end
      end
   endtask

   task automatic test_long_press();
      logic exp;
      int   n_long;
      sw = 1'b0;
      repeat (6) @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (press !== 1'b1) begin
         n_fail++;
         $display("FAIL long_entry_press: press=%b expected=1", press);
      end
      n_long = 0;
      for (int j = 1; j <= 30; j++) begin
         @(negedge clk);
         exp = LONG_EN && (j == 20);
         if (long_p === 1'b1) n_long++;
         n_tests++;
         if (long_p !== exp) begin
            n_fail++;
            $display("FAIL long_press cycle %0d: long=%b expected=%b", j, long_p, exp);
         end
      end
      n_tests++;
      if (n_long !== (LONG_EN ? 1 : 0)) begin
         n_fail++;
         $display("FAIL long_press_count: pulses=%0d expected=%0d", n_long, LONG_EN ? 1 : 0);
      end
      sw = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         n_tests++;
         if ({level, rel, long_p} !== {(k < 7), (k == 7), 1'b0}) begin
            n_fail++;
            $display("FAIL long_release cycle %0d: {level,rel,long}=%b expected=%b", k, {level, rel, long_p}, {(k < 7), (k == 7), 1'b0});
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_release_bounce();
      test_reset_mid();
      test_long_press();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Producer side of the push-button event interface on the DE0 board.
- Cleans a raw, bouncing, asynchronous switch/button pin into a stable level and single-cycle press/release event pulses.
- Downstream toggle/LED logic consumes these pulses directly and does no edge detection of its own.
- Sits between the top-level pin and any user-input consumer.

Parameters:
- DEBOUNCE_CYCLES, 500000, clk cycles input must be stable before an edge is accepted (10 ms @ 50 MHz); legal range >= 2.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed (DE0 buttons); 0 = pin reads 1 when pressed.
- LONG_CYCLES, 50000000, cycles of continuous debounced hold before a long-press event (1 s); used only with LONG_PRESS_EN.

Ports:
- clk  input  1  50 MHz system clock
- rst_n  input  1  asynchronous, active-low reset
- i_Switch  input  1  raw pin, asynchronous to clk
- o_Switch_Level  output  1  debounced pressed state (1 = pressed, polarity-normalised)
- o_Press_Pulse  output  1  one-cycle pulse on accepted press
- o_Release_Pulse  output  1  one-cycle pulse on accepted release
- o_Long_Press  output  1  one-cycle pulse on long hold (see Optional Feature)

Behaviour:
- One clock; rst_n asynchronous assert, active-low.
- Reset values:
  - All outputs 0; FSM in IDLE; counters 0.
  - Synchroniser flops reset to the released pin level: 1 if ACTIVE_LOW, else 0. No false press on reset release.
- Input path:
  - 2-flop synchroniser on i_Switch.
  - pressed = ACTIVE_LOW ? ~sync : sync.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
- IDLE:
  - pressed -> PRESS_WAIT, cnt <= 0.
- PRESS_WAIT:
  - !pressed -> IDLE (bounce rejected, no pulse).
  - Else if cnt == DEBOUNCE_CYCLES-1 -> HELD, o_Press_Pulse <= 1 for one cycle, o_Switch_Level <= 1.
  - Else cnt++.
- HELD:
  - !pressed -> RELEASE_WAIT, cnt <= 0.
- RELEASE_WAIT:
  - pressed -> HELD (bounce rejected, no pulse, level stays 1).
  - Else if cnt == DEBOUNCE_CYCLES-1 -> IDLE, o_Release_Pulse <= 1 for one cycle, o_Switch_Level <= 0.
  - Else cnt++.
- Latency: if edge N is the first edge sampling the new stable pin value, the event pulse is registered at edge N+2+DEBOUNCE_CYCLES and is high for exactly one cycle.
- Counter width: $clog2(DEBOUNCE_CYCLES); never wraps, because the counter is reset on every state entry.
- Event ordering:
  - Press and release pulses are never high together.
  - Presses and releases strictly alternate.
  - o_Switch_Level changes only in the same cycle as the corresponding pulse.
- Reset mid-operation (any state): immediate return to reset values, no pulse emitted during or after reset. A button still held at reset release produces a normal debounced press.
- All outputs are registered; no combinational path from i_Switch to any output.

Optional Feature:
- Macro: SWITCH_DEBOUNCE_LONG_PRESS_EN.
- Defined:
  - A hold counter (width $clog2(LONG_CYCLES)) clears on entry to HELD from PRESS_WAIT.
  - It counts every cycle in HELD or RELEASE_WAIT; a bounce return RELEASE_WAIT->HELD does not clear it.
  - When it reaches LONG_CYCLES-1, o_Long_Press pulses for one cycle.
  - At most one long-press pulse per press. The counter saturates and does not wrap.
  - An accepted release before the threshold yields no long press.
- Undefined: o_Long_Press tied 0, no hold counter synthesised; port list unchanged.

Decomposition:
- Shared package switch_pkg:
  - FSM state encoding (IDLE=2'd0, PRESS_WAIT=2'd1, HELD=2'd2, RELEASE_WAIT=2'd3).
  - Default timing constants (CLK_HZ=50000000, DEBOUNCE_MS=10).
- Sub-module sync_2ff (parameterised reset value, async active-low reset). It is reused by other pin-input blocks.
- FSM and counters stay in switch_debounce.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1):
1. Reset, hold i_Switch=1 for 10 cycles -> all outputs 0, no pulses.
2. Clean press: i_Switch 1->0 sampled at edge N, held -> o_Press_Pulse high only after edge N+6, o_Switch_Level=1 from the same edge.
3. Bounce: i_Switch low 3 cycles, high 1, low 3, high -> no pulse, level stays 0. Then a clean 10-cycle low -> exactly one press pulse.
4. Release with a 2-cycle bounce back to pressed inside RELEASE_WAIT -> no release pulse. A later stable high -> one o_Release_Pulse 6 edges after the stable sample, level 0.
5. rst_n asserted mid-PRESS_WAIT (cnt=2) -> outputs 0 immediately. Pin still low at rst_n deassert -> press pulse 6 edges after the first post-reset sample.
6. With SWITCH_DEBOUNCE_LONG_PRESS_EN: hold 30 cycles past the press pulse -> one o_Long_Press exactly 20 cycles after entering HELD, none after. Without the macro -> o_Long_Press stays 0.
